// File: rtl/cache_pkg.sv
// Shared types and address-field helpers for the 2-way write-through data cache.
package cache_pkg;

    typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

    localparam int SETS_DEF       = 64;
    localparam int LINE_WORDS_DEF = 2;
    localparam int DATA_W_DEF     = 32;
    localparam int INDEX_W        = $clog2(SETS_DEF);
    localparam int OFF_W          = $clog2(LINE_WORDS_DEF);
    localparam int LINE_W         = DATA_W_DEF * LINE_WORDS_DEF;

    // Helpers work on a zero-extended 64-bit address so any geometry can share them;
    // callers size-cast the result down to the field width they need.
    function automatic logic [63:0] field_mask(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic logic [63:0] addr_offset(input logic [63:0] a, input int off_w);
        return (a >> 2) & field_mask(off_w);
    endfunction

    function automatic logic [63:0] addr_index(input logic [63:0] a, input int off_w,
                                               input int idx_w);
        return (a >> (2 + off_w)) & field_mask(idx_w);
    endfunction

    function automatic logic [63:0] addr_tag(input logic [63:0] a, input int off_w,
                                             input int idx_w, input int tag_w);
        return (a >> (2 + off_w + idx_w)) & field_mask(tag_w);
    endfunction

endpackage

// File: rtl/cache_way_array.sv
// One cache way: valid/tag/data storage with async read, line fill, word update and flash clear.
module cache_way_array #(
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 10,
    localparam int IW        = $clog2(SETS),
    localparam int OW        = $clog2(LINE_WORDS),
    localparam int LW        = DATA_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IW-1:0]     idx_i,
    output logic              valid_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LW-1:0]     line_o,
    input  logic              line_we_i,
    input  logic [TAG_W-1:0]  tag_i,
    input  logic [LW-1:0]     line_i,
    input  logic              word_we_i,
    input  logic [OW-1:0]     off_i,
    input  logic [DATA_W-1:0] word_i,
    input  logic              clr_i
);
    logic [SETS-1:0]    valid_q;
    logic [TAG_W-1:0]   tag_q  [SETS];
    logic [LW-1:0]      data_q [SETS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            valid_q <= '0;
        else if (clr_i)     valid_q <= '0;
        else if (line_we_i) valid_q[idx_i] <= 1'b1;
    end

    // Word 0 lives in the most significant slot, matching the SRAM line layout.
    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[idx_i]  <= tag_i;
            data_q[idx_i] <= line_i;
        end else if (word_we_i) begin
            data_q[idx_i][(LINE_WORDS-1-int'(off_i))*DATA_W +: DATA_W] <= word_i;
        end
    end

    assign valid_o = valid_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = data_q[idx_i];

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative write-through data cache controller: miss/write FSM, LRU, flush, counters.
module set_assoc_cache_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 2,
    parameter int TAG_W      = 10,
    parameter int CNT_W      = 32,
    localparam int IW        = $clog2(SETS),
    localparam int OW        = $clog2(LINE_WORDS),
    localparam int LW        = DATA_W * LINE_WORDS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic              flush,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_rd,
    output logic              sram_wr,
    input  logic [LW-1:0]     sram_rdata,
    input  logic              sram_ready,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << (2 + OW)) - 64'd1);

    state_t             state_q, state_d;
    logic               victim_q, victim_d;
    logic [SETS-1:0]    lru_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [IW-1:0]      idx;
    logic [OW-1:0]      off;
    logic [TAG_W-1:0]   atag;
    logic [1:0]         way_v, way_hit, line_we, word_we;
    logic [1:0][TAG_W-1:0] way_tag;
    logic [1:0][LW-1:0] way_line;
    logic               hit, hit_way, victim_sel, clr;
    logic               lru_we, lru_val, hit_inc, miss_inc;

    function automatic logic [DATA_W-1:0] pick(input logic [LW-1:0] l, input logic [OW-1:0] o);
        return l[(LINE_WORDS-1-int'(o))*DATA_W +: DATA_W];
    endfunction

    assign idx  = IW'(addr_index(64'(cpu_addr), OW, IW));
    assign off  = OW'(addr_offset(64'(cpu_addr), OW));
    assign atag = TAG_W'(addr_tag(64'(cpu_addr), OW, IW, TAG_W));

    for (genvar w = 0; w < 2; w++) begin : g_way
        cache_way_array #(
            .DATA_W(DATA_W), .SETS(SETS), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W)
        ) u_way (
            .clk(clk), .rst(rst), .idx_i(idx),
            .valid_o(way_v[w]), .tag_o(way_tag[w]), .line_o(way_line[w]),
            .line_we_i(line_we[w]), .tag_i(atag), .line_i(sram_rdata),
            .word_we_i(word_we[w]), .off_i(off), .word_i(cpu_wdata),
            .clr_i(clr)
        );
        assign way_hit[w] = way_v[w] && (way_tag[w] == atag);
    end

    assign hit        = |way_hit;
    assign hit_way    = way_hit[1];
    // Fill empty ways in order before evicting by LRU.
    assign victim_sel = !way_v[0] ? 1'b0 : (!way_v[1] ? 1'b1 : lru_q[idx]);
    assign sram_wdata = cpu_wdata;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    always_comb begin
        state_d   = state_q;
        victim_d  = victim_q;
        cpu_ready = 1'b0;
        cpu_rdata = '0;
        sram_rd   = 1'b0;
        sram_wr   = 1'b0;
        sram_addr = cpu_addr;
        line_we   = '0;
        word_we   = '0;
        clr       = 1'b0;
        lru_we    = 1'b0;
        lru_val   = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_wr) begin
                    if (hit) begin
                        word_we[hit_way] = 1'b1;
                        lru_we           = 1'b1;
                        lru_val          = ~hit_way;
                    end
                    state_d = WRITE;
                end else if (cpu_rd) begin
                    if (hit) begin
                        cpu_ready = 1'b1;
                        cpu_rdata = pick(way_line[hit_way], off);
                        lru_we    = 1'b1;
                        lru_val   = ~hit_way;
                        hit_inc   = 1'b1;
                    end else begin
                        miss_inc = 1'b1;
                        victim_d = victim_sel;
                        state_d  = FILL;
                    end
                end else if (flush) begin
                    clr = 1'b1;
                end
            end
            FILL: begin
                sram_rd   = 1'b1;
                sram_addr = cpu_addr & LINE_MASK;
                if (sram_ready) begin
                    line_we[victim_q] = 1'b1;
                    lru_we            = 1'b1;
                    lru_val           = ~victim_q;
                    cpu_ready         = 1'b1;
                    cpu_rdata         = pick(sram_rdata, off);
                    state_d           = IDLE;
                end
            end
            WRITE: begin
                sram_wr = 1'b1;
                if (sram_ready) begin
                    cpu_ready = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            victim_q   <= 1'b0;
            lru_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            if (lru_we) lru_q[idx] <= lru_val;
            if (hit_inc && hit_cnt_q != '1)   hit_cnt_q  <= hit_cnt_q + 1'b1;
            if (miss_inc && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Table-driven bench for set_assoc_cache_ctrl with an SRAM model answering 3 cycles after a request.
module tb_set_assoc_cache_ctrl;

    logic        clk, rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, sram_addr, sram_wdata;
    logic        cpu_rd, cpu_wr, flush, cpu_ready, sram_rd, sram_wr, sram_ready;
    logic [63:0] sram_rdata;
    logic [31:0] hit_count, miss_count;
    logic        force_ready;
    logic [1:0]  cnt;
    logic [31:0] mem [1024];

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        fl;
        int          wait_c;
        logic [31:0] rdata;
        int          hits;
        int          misses;
        logic [31:0] saddr;
    } vec_t;

    vec_t tbl [15];
    vec_t sbq [$];

    set_assoc_cache_ctrl dut (
        .clk(clk), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .flush(flush), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_rd(sram_rd), .sram_wr(sram_wr),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // SRAM answers on the third cycle of a held request
    always @(posedge clk or posedge rst) begin
        if (rst) cnt <= 2'd0;
        else if ((sram_rd || sram_wr) && !sram_ready) cnt <= cnt + 2'd1;
        else cnt <= 2'd0;
    end
    assign sram_ready = ((sram_rd || sram_wr) && cnt == 2'd2) || force_ready;

    always_comb begin
        sram_rdata = {mem[{sram_addr[11:3], 1'b0}], mem[{sram_addr[11:3], 1'b1}]};
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int i);
        vec_t v, e;
        int waits, rdc, wrc;
        logic [31:0] sa, rd;
        bit done;
        v = tbl[i];
        @(negedge clk);
        cpu_addr = v.addr; cpu_wdata = v.wdata;
        cpu_wr = v.wr; cpu_rd = !v.wr; flush = v.fl;
        sbq.push_back(v);
        waits = 0; rdc = 0; wrc = 0; sa = '0; rd = '0; done = 1'b0;
        while (!done && waits < 20) begin
            #1;
            if (sram_rd) rdc++;
            if (sram_wr) wrc++;
            if (sram_rd || sram_wr) sa = sram_addr;
            if (cpu_ready) begin
                done = 1'b1;
                rd = cpu_rdata;
                if (sram_wr && sram_ready) mem[sram_addr[11:2]] = sram_wdata;
            end else begin
                @(negedge clk);
                waits++;
            end
        end
        e = sbq.pop_front();
        if (!done) begin
            n_vec++; n_err++;
            $display("FAIL vec%0d timeout: got no cpu_ready required cpu_ready", i);
        end else begin
            check($sformatf("vec%0d stall", i), 64'(waits), 64'(e.wait_c));
            check($sformatf("vec%0d sram_rd cycles", i), 64'(rdc), 64'(e.wr ? 0 : e.wait_c));
            check($sformatf("vec%0d sram_wr cycles", i), 64'(wrc), 64'(e.wr ? e.wait_c : 0));
            if (waits > 0) check($sformatf("vec%0d sram_addr", i), 64'(sa), 64'(e.saddr));
            if (!e.wr) check($sformatf("vec%0d rdata", i), 64'(rd), 64'(e.rdata));
        end
        @(posedge clk);
        #1;
        cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0;
        check($sformatf("vec%0d hit_count", i), 64'(hit_count), 64'(e.hits));
        check($sformatf("vec%0d miss_count", i), 64'(miss_count), 64'(e.misses));
    endtask

    initial begin
        // wr, addr, wdata, flush, stall, rdata, hits, misses, sram_addr
        tbl[0]  = '{1'b0, 32'h008, 32'h0,        1'b0, 3, 32'h11111111, 0, 1, 32'h008};
        tbl[1]  = '{1'b0, 32'h00C, 32'h0,        1'b0, 0, 32'h22222222, 1, 1, 32'h0};
        tbl[2]  = '{1'b0, 32'h008, 32'h0,        1'b0, 3, 32'h11111111, 1, 2, 32'h008};
        tbl[3]  = '{1'b0, 32'h208, 32'h0,        1'b0, 3, 32'hC0DE0208, 1, 3, 32'h208};
        tbl[4]  = '{1'b0, 32'h408, 32'h0,        1'b0, 3, 32'hC0DE0408, 1, 4, 32'h408};
        tbl[5]  = '{1'b0, 32'h208, 32'h0,        1'b0, 0, 32'hC0DE0208, 2, 4, 32'h0};
        tbl[6]  = '{1'b0, 32'h008, 32'h0,        1'b0, 3, 32'h11111111, 2, 5, 32'h008};
        tbl[7]  = '{1'b1, 32'h20C, 32'hDEADBEEF, 1'b0, 3, 32'h0,        2, 5, 32'h20C};
        tbl[8]  = '{1'b0, 32'h20C, 32'h0,        1'b0, 0, 32'hDEADBEEF, 3, 5, 32'h0};
        tbl[9]  = '{1'b1, 32'h80C, 32'h12345678, 1'b0, 3, 32'h0,        3, 5, 32'h80C};
        tbl[10] = '{1'b0, 32'h80C, 32'h0,        1'b0, 3, 32'h12345678, 3, 6, 32'h808};
        tbl[11] = '{1'b1, 32'h20C, 32'hCAFEF00D, 1'b1, 3, 32'h0,        3, 6, 32'h20C};
        tbl[12] = '{1'b0, 32'h208, 32'h0,        1'b0, 0, 32'hC0DE0208, 4, 6, 32'h0};
        tbl[13] = '{1'b0, 32'h20C, 32'h0,        1'b0, 0, 32'hCAFEF00D, 5, 6, 32'h0};
        tbl[14] = '{1'b0, 32'h00C, 32'h0,        1'b0, 3, 32'h22222222, 0, 1, 32'h008};

        for (int i = 0; i < 1024; i++) mem[i] = 32'(i * 4) ^ 32'hC0DE0000;
        mem[2] = 32'h11111111;
        mem[3] = 32'h22222222;

        rst = 1'b1; cpu_rd = 1'b0; cpu_wr = 1'b0; flush = 1'b0; force_ready = 1'b0;
        cpu_addr = '0; cpu_wdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset cpu_ready", 64'(cpu_ready), 64'(0));
        check("reset sram_rd", 64'(sram_rd), 64'(0));
        check("reset sram_wr", 64'(sram_wr), 64'(0));
        check("reset cpu_rdata", 64'(cpu_rdata), 64'(0));
        check("reset hit_count", 64'(hit_count), 64'(0));
        check("reset miss_count", 64'(miss_count), 64'(0));

        for (int i = 0; i < 2; i++) run_vec(i);

        // flush in IDLE with no request
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush cpu_ready", 64'(cpu_ready), 64'(0));
        @(posedge clk);
        #1;
        flush = 1'b0;

        for (int i = 2; i < 14; i++) run_vec(i);

        // reset during the second FILL cycle, then a stray sram_ready
        @(negedge clk);
        cpu_addr = 32'h00C; cpu_rd = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid-fill sram_rd", 64'(sram_rd), 64'(1));
        rst = 1'b1;
        #1;
        check("rst sram_rd drop", 64'(sram_rd), 64'(0));
        check("rst sram_wr", 64'(sram_wr), 64'(0));
        check("rst hit_count", 64'(hit_count), 64'(0));
        check("rst miss_count", 64'(miss_count), 64'(0));
        cpu_rd = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        force_ready = 1'b1;
        #1;
        check("late ready cpu_ready", 64'(cpu_ready), 64'(0));
        @(posedge clk);
        #1;
        force_ready = 1'b0;
        check("late ready idle sram_rd", 64'(sram_rd), 64'(0));

        run_vec(14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
